csr_machine_file: RTL and testbench
===================================

# csr_machine_file

Parametrised machine-mode CSR file for the single-hart RV32 core: executes CSRRW/RS/RC and their immediate forms, holds trap state, and handles trap entry and MRET. Sits beside the ALU in the execute stage. Returns CSR read data to the register file one cycle after issue and drives a PC redirect on trap or MRET. Generalises the first CSR unit with configurable counter width, a configurable count of HPM counters, and full trap bookkeeping.

## Interface
- `HART_ID`, default 0: value read from mhartid.
- `MTVEC_RESET`, default 32'h0000_8000: mtvec reset value (mode bits 00).
- `CNT_W`, default 64, range 33..64: implemented counter width. Bits ≥ CNT_W read 0.
- `N_HPM`, default 2, range 0..8: number of mhpmcounter3..(2+N_HPM) / …h pairs.
- `MISA_EXT`, default 26'h000100 (I only): misa[25:0].
- Reset is `rst`: synchronous, active-high. Clock is `clk`.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `csr_en` in 1: CSR instruction issue, one-cycle pulse.
- `funct3` in 3: instruction funct3.
- `csr_addr` in 12: CSR address (I-immediate).
- `rs1_idx` in 5: rs1 index; zimm for the immediate forms.
- `rd_idx` in 5: destination index.
- `rs1_data` in 32: rs1 value.
- `rd_data` out 32: old CSR value, registered.
- `rd_wr` out 1: register-file write strobe.
- `illegal` out 1: illegal CSR access pulse.
- `retire` in 1: instruction retired this cycle.
- `hpm_event` in max(N_HPM,1): per-HPM-counter increment events.
- `exc_valid` in 1: take an exception this cycle.
- `exc_cause` in 5: mcause code. Interrupt bit is 0.
- `exc_pc` in 32: faulting PC.
- `exc_tval` in 32: mtval value.
- `mret` in 1: MRET executed.
- `redirect` out 1: PC redirect pulse.
- `redirect_pc` out 32: redirect target.

## Operation
**Implemented CSRs**
- RO: mvendorid F11, marchid F12, mimpid F13 (all read 0); mhartid F14 (HART_ID); misa 301 (MXL=01, MISA_EXT).
- mstatus 300:
  - Only MIE[3] and MPIE[7] are writable.
  - MPP[12:11] is hardwired 11.
  - All other bits read 0.
- mtvec 305:
  - BASE[31:2] is writable.
  - MODE is WARL: a write of 2 or 3 leaves MODE unchanged.
  - Trap target is always BASE, since interrupts are absent.
- mscratch 340 is fully writable.
- mepc 341: bits [1:0] are forced to 0.
- mcause 342 and mtval 343 are fully writable.
- Counters:
  - mcycle B00 / mcycleh B80.
  - minstret B02 / minstreth B82.
  - mhpmcounter3+i B03+i / B83+i, for i < N_HPM.
- Any other address is illegal, including HPM addresses ≥ N_HPM.

**Write operand**
- Operand is rs1_data for funct3 001/010/011.
- Operand is zero-extended rs1_idx for 101/110/111.
- funct3 000 or 100 is illegal.
- Write is performed:
  - always for RW/RWI;
  - for S/C forms only when rs1_idx ≠ 0.
- New value is operand (RW), old|operand (RS), or old&~operand (RC).

**Illegality**
- A CSR access is illegal if any of these hold:
  - unknown address;
  - bad funct3;
  - a performed write to csr_addr[11:10]==11.
- An illegal access causes no CSR change, `rd_wr`=0 and `illegal`=1.
- The core converts `illegal` into `exc_valid` with cause 2.

**Counters**
- mcycle increments every cycle.
- minstret increments on `retire`.
- HPM counter i increments on `hpm_event[i]`.
- All counters wrap modulo 2^CNT_W.
- A CSR write to either half of a counter in a cycle replaces that cycle's increment. The other half keeps its old value.

**Trap entry** (`exc_valid`) updates these registers at the edge:
- mepc ← {exc_pc[31:2],00};
- mcause ← exc_cause zero-extended;
- mtval ← exc_tval;
- MPIE ← MIE;
- MIE ← 0.

**MRET** (`mret`): MIE ← MPIE, MPIE ← 1.

**Priority**
- `exc_valid` beats `mret`, which beats the `csr_en` operation.
- Every lower-priority event in the same cycle is discarded entirely: no CSR change, `rd_wr`=0, `illegal`=0.
- Counter increments still occur.

## Timing
- `csr_en` is sampled at edge N; the CSR update happens at edge N.
- At cycle N+1:
  - `rd_data` holds the pre-write value;
  - `rd_wr` = legal && rd_idx≠0;
  - `illegal` is asserted if the access was illegal.
- `rd_data` holds its value until the next issue.
- A read of mcycle returns the value before edge N's increment.
- Trap taken at edge N: cycle N+1 has `redirect`=1 and `redirect_pc`=mtvec BASE as of before edge N.
- MRET at edge N: cycle N+1 has `redirect`=1 and `redirect_pc`=mepc as of before edge N.
- `redirect`, `rd_wr` and `illegal` are one-cycle pulses.
- Back-to-back issues every cycle are supported.

**Reset**
- mstatus=0x1800 and mtvec=MTVEC_RESET.
- All other writable CSRs and counters are 0.
- All outputs are 0.
- `rst` asserted mid-operation cancels any pending pulse at the next cycle.

## Test plan
- After reset:
  - read 300 returns 0x00001800;
  - read 305 returns 0x00008000;
  - read 301 returns 0x40000100;
  - read F14 returns HART_ID.
- CSRRW 340 with rs1_data=0xDEADBEEF, then CSRRS 340 with zimm=1 (110): the second read returns 0xDEADBEEF, and mscratch becomes 0xDEADBEEF.
- CSRRS F11 with rs1_idx=0 is legal and returns 0. CSRRW F11 gives `illegal`=1 and `rd_wr`=0. Address 7C0 is illegal.
- Exception: mstatus MIE=1, mtvec=0x100, exc_pc=0x2006, cause 2, tval=0x1234.
  - Required: redirect_pc=0x100 next cycle; mepc=0x2004; mcause=2; mtval=0x1234; mstatus=0x1880.
  - Then `mret`: redirect_pc=0x2004 and mstatus=0x1888.
- Write mcycle=0xFFFFFFFF and mcycleh=0 (CNT_W=64): two cycles later mcycleh reads 1. With CNT_W=40, mcycleh=0xFF wraps to 0.
- `exc_valid`, `mret` and a CSRRW to 340 in the same cycle: only the trap occurs, mscratch is unchanged, and `rd_wr`=0.

Source files
------------

// File: rtl/csr_machine_file.sv
// Machine-mode CSR file for the single-hart RV32 core: Zicsr execution, counters,
// trap entry and MRET with a registered PC redirect.
module csr_machine_file #(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_8000,
    parameter int          CNT_W       = 64,
    parameter int          N_HPM       = 2,
    parameter logic [25:0] MISA_EXT    = 26'h000100,
    localparam int         HPM_W       = (N_HPM > 0) ? N_HPM : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             csr_en,
    input  logic [2:0]       funct3,
    input  logic [11:0]      csr_addr,
    input  logic [4:0]       rs1_idx,
    input  logic [4:0]       rd_idx,
    input  logic [31:0]      rs1_data,
    output logic [31:0]      rd_data,
    output logic             rd_wr,
    output logic             illegal,
    input  logic             retire,
    input  logic [HPM_W-1:0] hpm_event,
    input  logic             exc_valid,
    input  logic [4:0]       exc_cause,
    input  logic [31:0]      exc_pc,
    input  logic [31:0]      exc_tval,
    input  logic             mret,
    output logic             redirect,
    output logic [31:0]      redirect_pc
);
    localparam int         N_CNT   = N_HPM + 2;
    localparam int         IDX_W   = $clog2(N_CNT);
    localparam logic [5:0] HPM_END = 6'(N_HPM + 3);

    logic             mie_reg, mpie_reg;
    logic [29:0]      mtvec_base_reg;
    logic [1:0]       mtvec_mode_reg;
    logic [31:0]      mscratch_reg, mcause_reg, mtval_reg;
    logic [29:0]      mepc_reg;
    logic [CNT_W-1:0] cnt_q [N_CNT];

    logic [31:0]      operand, rdata, wdata, mstatus_val;
    logic             bad_f3, do_write, addr_ok, is_ill, csr_act, wr_ok;
    logic             cnt_hit;
    logic [IDX_W-1:0] cnt_idx;
    logic [CNT_W-1:0] cnt_sel;

    always_comb begin
        operand  = funct3[2] ? {27'd0, rs1_idx} : rs1_data;
        bad_f3   = (funct3[1:0] == 2'b00);
        do_write = (funct3[1:0] == 2'b01) || (rs1_idx != 5'd0);

        // Counters live at Bxx (low half) and B8x (high half); B01 (time) is absent.
        cnt_hit = 1'b0;
        cnt_idx = '0;
        if (csr_addr[11:8] == 4'hB && csr_addr[6:5] == 2'b00) begin
            if (csr_addr[4:0] == 5'd0) begin
                cnt_hit = 1'b1;
            end else if (csr_addr[4:0] == 5'd2) begin
                cnt_hit = 1'b1;
                cnt_idx = IDX_W'(1);
            end else if (csr_addr[4:0] >= 5'd3 && {1'b0, csr_addr[4:0]} < HPM_END) begin
                cnt_hit = 1'b1;
                cnt_idx = IDX_W'(csr_addr[4:0] - 5'd1);
            end
        end
        cnt_sel = cnt_q[cnt_idx];

        mstatus_val    = 32'h0000_1800;
        mstatus_val[7] = mpie_reg;
        mstatus_val[3] = mie_reg;

        addr_ok = 1'b1;
        rdata   = 32'd0;
        case (csr_addr)
            12'hF11, 12'hF12, 12'hF13: rdata = 32'd0;
            12'hF14: rdata = HART_ID;
            12'h301: rdata = {2'b01, 4'b0000, MISA_EXT};
            12'h300: rdata = mstatus_val;
            12'h305: rdata = {mtvec_base_reg, mtvec_mode_reg};
            12'h340: rdata = mscratch_reg;
            12'h341: rdata = {mepc_reg, 2'b00};
            12'h342: rdata = mcause_reg;
            12'h343: rdata = mtval_reg;
            default: begin
                if (cnt_hit) begin
                    rdata = csr_addr[7] ? 32'(cnt_sel[CNT_W-1:32]) : cnt_sel[31:0];
                end else begin
                    addr_ok = 1'b0;
                end
            end
        endcase

        case (funct3[1:0])
            2'b01:   wdata = operand;
            2'b10:   wdata = rdata | operand;
            2'b11:   wdata = rdata & ~operand;
            default: wdata = rdata;
        endcase

        is_ill  = !addr_ok || bad_f3 || (do_write && csr_addr[11:10] == 2'b11);
        csr_act = csr_en && !exc_valid && !mret;
        wr_ok   = csr_act && !is_ill && do_write;
    end

    // A CSR write to either half takes the place of that cycle's increment.
    for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
        logic             cnt_inc;
        logic             cnt_wr;
        logic [CNT_W-1:0] cnt_reg;

        if (gi == 0) begin : g_cycle
            assign cnt_inc = 1'b1;
        end else if (gi == 1) begin : g_instret
            assign cnt_inc = retire;
        end else begin : g_hpm
            assign cnt_inc = hpm_event[gi-2];
        end

        assign cnt_wr = wr_ok && cnt_hit && (cnt_idx == IDX_W'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg <= '0;
            end else if (cnt_wr) begin
                if (csr_addr[7]) begin
                    cnt_reg <= {wdata[CNT_W-33:0], cnt_reg[31:0]};
                end else begin
                    cnt_reg <= {cnt_reg[CNT_W-1:32], wdata};
                end
            end else if (cnt_inc) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end

        assign cnt_q[gi] = cnt_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_reg        <= 1'b0;
            mpie_reg       <= 1'b0;
            mtvec_base_reg <= MTVEC_RESET[31:2];
            mtvec_mode_reg <= MTVEC_RESET[1:0];
            mscratch_reg   <= 32'd0;
            mepc_reg       <= 30'd0;
            mcause_reg     <= 32'd0;
            mtval_reg      <= 32'd0;
            rd_data        <= 32'd0;
            rd_wr          <= 1'b0;
            illegal        <= 1'b0;
            redirect       <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            rd_wr    <= 1'b0;
            illegal  <= 1'b0;
            redirect <= 1'b0;
            if (exc_valid) begin
                mepc_reg    <= exc_pc[31:2];
                mcause_reg  <= {27'd0, exc_cause};
                mtval_reg   <= exc_tval;
                mpie_reg    <= mie_reg;
                mie_reg     <= 1'b0;
                redirect    <= 1'b1;
                redirect_pc <= {mtvec_base_reg, 2'b00};
            end else if (mret) begin
                mie_reg     <= mpie_reg;
                mpie_reg    <= 1'b1;
                redirect    <= 1'b1;
                redirect_pc <= {mepc_reg, 2'b00};
            end else if (csr_en) begin
                rd_data <= rdata;
                rd_wr   <= !is_ill && (rd_idx != 5'd0);
                illegal <= is_ill;
                if (wr_ok) begin
                    case (csr_addr)
                        12'h300: begin
                            mie_reg  <= wdata[3];
                            mpie_reg <= wdata[7];
                        end
                        12'h305: begin
                            mtvec_base_reg <= wdata[31:2];
                            if (!wdata[1]) mtvec_mode_reg <= wdata[1:0];
                        end
                        12'h340: mscratch_reg <= wdata;
                        12'h341: mepc_reg     <= wdata[31:2];
                        12'h342: mcause_reg   <= wdata;
                        12'h343: mtval_reg    <= wdata;
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_csr_machine_file.sv
// Scoreboard bench for csr_machine_file: driver runs a spec-level model per edge and
// queues the expected outputs; an independent monitor compares after every edge.
module tb_csr_machine_file;
    localparam logic [31:0] HART = 32'h0000_0007;
    localparam int          CW   = 40;
    localparam int          NH   = 3;
    localparam int          NC   = NH + 2;
    localparam logic [63:0] MASK = (64'd1 << CW) - 64'd1;

    logic          clk, rst, csr_en, retire, exc_valid, mret;
    logic [2:0]    funct3;
    logic [11:0]   csr_addr;
    logic [4:0]    rs1_idx, rd_idx, exc_cause;
    logic [31:0]   rs1_data, exc_pc, exc_tval;
    logic [NH-1:0] hpm_event;
    logic [31:0]   rd_data, redirect_pc;
    logic          rd_wr, illegal, redirect;

    csr_machine_file #(.HART_ID(HART), .CNT_W(CW), .N_HPM(NH)) dut (
        .clk(clk), .rst(rst), .csr_en(csr_en), .funct3(funct3), .csr_addr(csr_addr),
        .rs1_idx(rs1_idx), .rd_idx(rd_idx), .rs1_data(rs1_data), .rd_data(rd_data),
        .rd_wr(rd_wr), .illegal(illegal), .retire(retire), .hpm_event(hpm_event),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .mret(mret), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          edge_no;
        bit          rd_wr;
        bit          ill;
        bit          redir;
        bit          chk_rdd;
        logic [31:0] rpc;
        logic [31:0] rdd;
    } exp_t;
    exp_t q[$];

    int vectors = 0;
    int miscompares = 0;
    int edge_cnt = 0;

    // Architectural state as the programmer sees it.
    bit          m_mie, m_mpie;
    logic [29:0] m_base;
    logic [1:0]  m_mode;
    logic [31:0] m_scratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cnt [NC];

    function automatic logic [11:0] cnt_addr(int k);
        if (k == 0) return 12'hB00;
        if (k == 1) return 12'hB02;
        return 12'hB01 + 12'(k);
    endfunction

    function automatic bit m_read(input logic [11:0] a, output logic [31:0] v);
        v = 32'd0;
        case (a)
            12'hF11, 12'hF12, 12'hF13: return 1'b1;
            12'hF14: begin v = HART; return 1'b1; end
            12'h301: begin v = 32'h4000_0100; return 1'b1; end
            12'h300: begin v = 32'h1800; v[7] = m_mpie; v[3] = m_mie; return 1'b1; end
            12'h305: begin v = {m_base, m_mode}; return 1'b1; end
            12'h340: begin v = m_scratch; return 1'b1; end
            12'h341: begin v = m_mepc; return 1'b1; end
            12'h342: begin v = m_mcause; return 1'b1; end
            12'h343: begin v = m_mtval; return 1'b1; end
            default: ;
        endcase
        for (int k = 0; k < NC; k++) begin
            if (a == cnt_addr(k)) begin v = m_cnt[k][31:0]; return 1'b1; end
            if (a == (cnt_addr(k) | 12'h080)) begin v = m_cnt[k][63:32]; return 1'b1; end
        end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        m_mie = 0; m_mpie = 0; m_base = 30'h0000_2000; m_mode = 2'b00;
        m_scratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        for (int k = 0; k < NC; k++) m_cnt[k] = 64'd0;
    endfunction

    // Predict what the DUT shows after the upcoming clock edge and advance the model.
    function automatic void model_edge();
        exp_t        e;
        logic [63:0] old [NC];
        logic [31:0] val, op, nv;
        bit          ok, wr, ill;
        e.edge_no = edge_cnt + 1;
        e.rd_wr = 0; e.ill = 0; e.redir = 0; e.chk_rdd = 0; e.rpc = 0; e.rdd = 0;
        if (rst) begin
            model_reset();
            e.chk_rdd = 1;
            q.push_back(e);
            return;
        end
        ok = m_read(csr_addr, val);
        for (int k = 0; k < NC; k++) old[k] = m_cnt[k];
        m_cnt[0] = (m_cnt[0] + 1) & MASK;
        if (retire) m_cnt[1] = (m_cnt[1] + 1) & MASK;
        for (int k = 0; k < NH; k++) if (hpm_event[k]) m_cnt[k+2] = (m_cnt[k+2] + 1) & MASK;
        if (exc_valid) begin
            e.redir = 1; e.rpc = {m_base, 2'b00};
            m_mepc = exc_pc & 32'hFFFF_FFFC; m_mcause = 32'(exc_cause); m_mtval = exc_tval;
            m_mpie = m_mie; m_mie = 0;
        end else if (mret) begin
            e.redir = 1; e.rpc = m_mepc;
            m_mie = m_mpie; m_mpie = 1;
        end else if (csr_en) begin
            op  = funct3[2] ? 32'(rs1_idx) : rs1_data;
            wr  = (funct3[1:0] == 2'b01) || (rs1_idx != 0);
            nv  = (funct3[1:0] == 2'b01) ? op : (funct3[1:0] == 2'b10) ? (val | op) : (val & ~op);
            ill = !ok || funct3[1:0] == 2'b00 || (wr && csr_addr[11:10] == 2'b11);
            e.ill = ill;
            e.rd_wr = !ill && rd_idx != 0;
            e.chk_rdd = e.rd_wr;
            e.rdd = val;
            if (!ill && wr) begin
                case (csr_addr)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h305: begin m_base = nv[31:2]; if (nv[1:0] < 2) m_mode = nv[1:0]; end
                    12'h340: m_scratch = nv;
                    12'h341: m_mepc = nv & 32'hFFFF_FFFC;
                    12'h342: m_mcause = nv;
                    12'h343: m_mtval = nv;
                    default: ;
                endcase
                for (int k = 0; k < NC; k++) begin
                    if (csr_addr == cnt_addr(k))
                        m_cnt[k] = (old[k] & ~64'hFFFF_FFFF) | 64'(nv);
                    if (csr_addr == (cnt_addr(k) | 12'h080))
                        m_cnt[k] = ((64'(nv) << 32) | (old[k] & 64'hFFFF_FFFF)) & MASK;
                end
            end
        end
        q.push_back(e);
    endfunction

    always @(posedge clk) begin
        exp_t e;
        edge_cnt++;
        #1;
        if (q.size() > 0 && q[0].edge_no == edge_cnt) begin
            e = q.pop_front();
            vectors++;
            if (rd_wr !== e.rd_wr || illegal !== e.ill || redirect !== e.redir ||
                (e.redir && redirect_pc !== e.rpc) || (e.chk_rdd && rd_data !== e.rdd)) begin
                miscompares++;
                $display("FAIL cycle %0d: got rd_wr=%b illegal=%b redirect=%b pc=%h rd_data=%h, want rd_wr=%b illegal=%b redirect=%b pc=%h rd_data=%h",
                         edge_cnt, rd_wr, illegal, redirect, redirect_pc, rd_data,
                         e.rd_wr, e.ill, e.redir, e.rpc, e.rdd);
            end else begin
                $display("ok   cycle %0d: rd_wr=%b illegal=%b redirect=%b pc=%h rd_data=%h",
                         edge_cnt, rd_wr, illegal, redirect, redirect_pc, rd_data);
            end
        end
    end

    task automatic cyc();
        retire    = 1'($urandom);
        hpm_event = NH'($urandom);
        model_edge();
        @(negedge clk);
        rst = 0; csr_en = 0; exc_valid = 0; mret = 0;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                         input logic [31:0] d, input logic [4:0] rd);
        csr_en = 1; funct3 = f3; csr_addr = a; rs1_idx = r1; rs1_data = d; rd_idx = rd;
        cyc();
    endtask

    task automatic rd(input logic [11:0] a);
        issue(3'b010, a, 5'd0, 32'd0, 5'd1);
    endtask

    logic [11:0] addr_pool [28] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
        12'h343, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
        12'hB03, 12'hB04, 12'hB05, 12'hB83, 12'hB84, 12'hB85, 12'hB01, 12'hB06, 12'hB86,
        12'h7C0, 12'h344, 12'hC00, 12'h300};

    initial begin
        int wait_cnt;
        rst = 1; csr_en = 0; funct3 = 0; csr_addr = 0; rs1_idx = 0; rd_idx = 0; rs1_data = 0;
        exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0; mret = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin rst = 1; cyc(); end

        if (rd_data !== 32'd0 || rd_wr !== 1'b0 || illegal !== 1'b0 ||
            redirect !== 1'b0 || redirect_pc !== 32'd0) begin
            miscompares++;
            $display("FAIL reset state: rd_data=%h rd_wr=%b illegal=%b redirect=%b pc=%h, want all 0",
                     rd_data, rd_wr, illegal, redirect, redirect_pc);
        end else begin
            $display("ok   reset state: all outputs 0");
        end

        // Reset values and read-only registers.
        rd(12'h300); rd(12'h305); rd(12'h301); rd(12'hF14); rd(12'hB00);
        // mscratch write then set-immediate.
        issue(3'b001, 12'h340, 5'd7, 32'hDEAD_BEEF, 5'd2);
        issue(3'b110, 12'h340, 5'd1, 32'd0, 5'd3);
        rd(12'h340);
        // Read-only and unknown addresses, bad funct3.
        issue(3'b010, 12'hF11, 5'd0, 32'd0, 5'd4);
        issue(3'b001, 12'hF11, 5'd3, 32'h1, 5'd4);
        rd(12'h7C0); rd(12'hB06); rd(12'hB86); rd(12'hB05);
        issue(3'b000, 12'h340, 5'd0, 32'd0, 5'd1);
        issue(3'b100, 12'h340, 5'd0, 32'd0, 5'd1);
        // Trap entry and MRET.
        issue(3'b110, 12'h300, 5'd8, 32'd0, 5'd0);
        issue(3'b001, 12'h305, 5'd1, 32'h0000_0100, 5'd0);
        exc_valid = 1; exc_cause = 5'd2; exc_pc = 32'h2006; exc_tval = 32'h1234; cyc();
        rd(12'h341); rd(12'h342); rd(12'h343); rd(12'h300);
        mret = 1; cyc();
        rd(12'h300);
        // mtvec MODE is WARL.
        issue(3'b001, 12'h305, 5'd1, 32'h0000_0203, 5'd1);
        rd(12'h305);
        // Counter carry across halves and wrap at CNT_W.
        issue(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF, 5'd0);
        issue(3'b001, 12'hB80, 5'd1, 32'h0, 5'd0);
        rd(12'hB80); rd(12'hB80); rd(12'hB00);
        issue(3'b001, 12'hB80, 5'd1, 32'h0000_FFFF, 5'd0);
        issue(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF, 5'd0);
        rd(12'hB80); rd(12'hB00);
        // Trap, MRET and CSR write all in one cycle: only the trap happens.
        csr_en = 1; funct3 = 3'b001; csr_addr = 12'h340; rs1_idx = 5'd1; rs1_data = 32'h5555_AAAA;
        rd_idx = 5'd5; exc_valid = 1; mret = 1; exc_cause = 5'd11; exc_pc = 32'h40; exc_tval = 0;
        cyc();
        rd(12'h340);
        mret = 1; csr_en = 1; funct3 = 3'b001; csr_addr = 12'h340; rd_idx = 5'd5; cyc();
        rd(12'h340);
        // Reset collides with an issue.
        rst = 1; csr_en = 1; funct3 = 3'b001; csr_addr = 12'h340; rs1_idx = 5'd1; rd_idx = 5'd6;
        cyc();
        rd(12'h340); rd(12'h300);

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            csr_en    = ($urandom_range(0, 1) == 1);
            funct3    = 3'($urandom);
            csr_addr  = addr_pool[$urandom_range(0, 27)];
            rs1_idx   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rd_idx    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rs1_data  = $urandom;
            exc_valid = ($urandom_range(0, 15) == 0);
            mret      = ($urandom_range(0, 15) == 0);
            exc_cause = 5'($urandom);
            exc_pc    = $urandom;
            exc_tval  = $urandom;
            rst       = ($urandom_range(0, 127) == 0);
            cyc();
        end
        for (int i = 0; i < 3; i++) cyc();

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL wait expired: %0d expected transactions never observed", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
